regfile_nrd: RTL and testbench
==============================

Name: regfile_nrd

Overview:
- Parametrised register file for the ARM datapath: NREGS entries of WIDTH bits, one write port and NRD independent read ports.
- The highest-numbered register is hard-wired to zero (XZR).
- Each read port is built from a parametrised N:1 word mux. The mux supersedes the fixed 32:1 per-bit mux array.
- Adds write-through bypass and an optional registered-read mode, so the same block serves both single-cycle and pipelined cores.

Parameters:
- WIDTH, 64, data word width in bits.
- NREGS, 32, number of architectural registers; power of two, 2..64.
- NRD, 2, number of read ports, 1..4.
- READ_REG, 0: 0 = combinational read; 1 = read data registered, 1-cycle latency.
- BYPASS, 1: 1 = a read of the address being written in the same cycle returns wr_data.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- wr_en  input  1  write enable.
- wr_addr  input  AW  write register index, AW = $clog2(NREGS).
- wr_data  input  WIDTH  write data.
- rd_addr  input  [NRD-1:0][AW-1:0]  read indices, one per port.
- rd_data  output  [NRD-1:0][WIDTH-1:0]  read data, one per port.

Behaviour:
- Storage: NREGS-1 writable registers, indices 0..NREGS-2. Index NREGS-1 always reads 0. Writes to index NREGS-1 are discarded.
- Write: on rising clk, if wr_en=1, reset=0 and wr_addr != NREGS-1, then reg[wr_addr] <= wr_data. Otherwise no register changes.
- Reset: while reset=1 at a rising edge, all registers clear to 0 and any write in that cycle is ignored.
  - READ_REG=1: rd_data registers also clear to 0 on that edge.
  - READ_REG=0: rd_data reflects the cleared registers immediately after the edge.
- Reset asserted mid-operation overrides everything; the write on the reset edge is lost.
- Read selection per port p: sel_p = rd_addr[p].
  - If sel_p == NREGS-1, the value is 0.
  - Else if BYPASS=1, wr_en=1 and wr_addr == sel_p, the value is wr_data.
  - Else the value is reg[sel_p].
- READ_REG=0: rd_data[p] equals the selected value combinationally. It changes in the same cycle rd_addr changes.
- READ_REG=1: rd_data[p] <= selected value at the rising edge. Data for an address presented in cycle N is visible in cycle N+1.
  - With BYPASS=1, a same-cycle write is returned.
  - With BYPASS=0, the old contents are returned.
- Multiple ports may read the same index simultaneously and receive identical data.
- All ports are independent; no read port affects storage.
- A write followed by a read in the next cycle always returns the new value, regardless of BYPASS.
- No X propagation: every rd_data bit is defined after the first reset edge.
- Widths: no arithmetic. Addresses are compared at full AW width with no truncation.

Decomposition:
- Package regfile_pkg:
  - function clog2w(n) for AW.
  - localparam helper ZERO_IDX(n) = n-1.
  - typedef for the read-address vector.
- Sub-module mux_n1_word #(WIDTH, N): word-wide N:1 mux with $clog2(N)-bit sel, instantiated once per read port.
- Bypass compare, zero-register override and optional output register live in regfile_nrd.

Test Plan:
1. Reset then read: reset=1 for one edge, then rd_addr={0,5} -> rd_data={0,0}. With READ_REG=1, rd_data is 0 on the reset edge.
2. Write/readback: write 0x0123_4567_89AB_CDEF to reg 3, next cycle rd_addr[0]=3 -> rd_data[0]=0x0123_4567_89AB_CDEF. rd_addr[1]=4 -> rd_data[1]=0.
3. Zero register: wr_en=1, wr_addr=31, wr_data=all-ones, then rd_addr={31,31} -> rd_data={0,0}. No other register changes.
4. Bypass: reg 7 holds 0x11; same cycle wr_en=1, wr_addr=7, wr_data=0x22, rd_addr[0]=7.
   - BYPASS=1: rd_data[0]=0x22 (READ_REG=0 same cycle; READ_REG=1 next cycle).
   - BYPASS=0: rd_data[0]=0x11.
5. Reset mid-write: reset=1 and wr_en=1, wr_addr=2, wr_data=0xFF on the same edge -> reg 2 reads 0 afterwards.
6. Parameter sweep: WIDTH=3, NREGS=8, NRD=3.
   - Write reg i = i for i=0..6, read all 8 indices across the 3 ports.
   - Expect value i at each index i, and 0 at index 7.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared helpers for the register file: address-width and zero-register index
// functions, plus the widest read-address vector type.
package regfile_pkg;

    localparam int MAX_NRD = 4;
    localparam int MAX_AW  = 6;

    typedef logic [MAX_NRD-1:0][MAX_AW-1:0] rd_addr_vec_t;

    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // XZR is always the highest-numbered register.
    function automatic int zero_idx(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/mux_n1_word.sv
// Word-wide N:1 multiplexer; one instance per register-file read port.
module mux_n1_word
    import regfile_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N     = 32
) (
    input  logic [N-1:0][WIDTH-1:0]   in_words,
    input  logic [clog2w(N)-1:0]      sel,
    output logic [WIDTH-1:0]          out_word
);

    // N is a power of two, so every sel value addresses a real word.
    assign out_word = in_words[sel];

endmodule

// File: rtl/regfile_nrd.sv
// Multi-read-port register file with a hard-wired zero register, optional
// write-through bypass and optional registered read data.
module regfile_nrd
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int READ_REG = 0,
    parameter int BYPASS   = 1,
    localparam int AW      = clog2w(NREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [NRD-1:0][AW-1:0]     rd_addr,
    output logic [NRD-1:0][WIDTH-1:0]  rd_data
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(zero_idx(NREGS));

    logic [NREGS-2:0][WIDTH-1:0] regs_q, regs_d;
    logic [NREGS-1:0][WIDTH-1:0] mux_in;
    logic [NRD-1:0][WIDTH-1:0]   mux_out;
    logic [NRD-1:0][WIDTH-1:0]   sel_val;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS - 1; i++) begin
            if (wr_en && wr_addr == AW'(i)) regs_d[i] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    // The mux sees NREGS words; the top word is the constant zero register.
    assign mux_in = {{WIDTH{1'b0}}, regs_q};

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [WIDTH-1:0] val;

        mux_n1_word #(.WIDTH(WIDTH), .N(NREGS)) u_mux (
            .in_words (mux_in),
            .sel      (rd_addr[p]),
            .out_word (mux_out[p])
        );

        // Zero check comes first so a write to XZR is never bypassed.
        always_comb begin
            val = mux_out[p];
            if (rd_addr[p] == ZERO_IDX)
                val = '0;
            else if (BYPASS != 0 && wr_en && wr_addr == rd_addr[p])
                val = wr_data;
        end

        assign sel_val[p] = val;
    end

    if (READ_REG != 0) begin : g_rreg
        logic [NRD-1:0][WIDTH-1:0] rd_q, rd_d;

        always_comb begin
            rd_d = sel_val;
        end

        always_ff @(posedge clk) begin
            if (reset) rd_q <= '0;
            else       rd_q <= rd_d;
        end

        assign rd_data = rd_q;
    end else begin : g_rcomb
        assign rd_data = sel_val;
    end

endmodule

// File: tb/tb_regfile_nrd.sv
// Directed bench: four 64-bit variants (READ_REG x BYPASS) on shared stimulus
// plus a narrow 3-bit / 8-entry / 3-port instance.
module tb_regfile_nrd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, wr_en;
    logic [4:0]        wr_addr;
    logic [63:0]       wr_data;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][63:0]  rd_c, rd_r, rd_nb, rd_rnb;

    logic              s_wr_en;
    logic [2:0]        s_wr_addr, s_wr_data;
    logic [2:0][2:0]   s_rd_addr, s_rd_data;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;

    regfile_nrd #(.READ_REG(0), .BYPASS(1)) u_c (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_c));
    regfile_nrd #(.READ_REG(1), .BYPASS(1)) u_r (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_r));
    regfile_nrd #(.READ_REG(0), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_nb));
    regfile_nrd #(.READ_REG(1), .BYPASS(0)) u_rnb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_rnb));
    regfile_nrd #(.WIDTH(3), .NREGS(8), .NRD(3)) u_s (
        .clk(clk), .reset(reset), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
        .wr_data(s_wr_data), .rd_addr(s_rd_addr), .rd_data(s_rd_data));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = {5'd5, 5'd0};
        s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr = '0;
        tick;
        reset = 1'b0;
        #1;
        checks++;
        if (rd_c !== '0) begin failures++; $display("FAIL reset_comb got=%h exp=0", rd_c); end
        checks++;
        if (rd_r !== '0) begin failures++; $display("FAIL reset_reg got=%h exp=0", rd_r); end
        checks++;
        if (rd_nb !== '0) begin failures++; $display("FAIL reset_nb got=%h exp=0", rd_nb); end
        checks++;
        if (s_rd_data !== '0) begin failures++; $display("FAIL reset_sweep got=%h exp=0", s_rd_data); end
    endtask

    task automatic test_write_readback;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = D3;
        tick;
        wr_en = 1'b0;
        rd_addr = {5'd4, 5'd3};
        #1;
        checks++;
        if (rd_c[0] !== D3) begin failures++; $display("FAIL wrrb_c0 got=%h exp=%h", rd_c[0], D3); end
        checks++;
        if (rd_c[1] !== 64'd0) begin failures++; $display("FAIL wrrb_c1 got=%h exp=0", rd_c[1]); end
        checks++;
        if (rd_nb[0] !== D3) begin failures++; $display("FAIL wrrb_nb0 got=%h exp=%h", rd_nb[0], D3); end
        tick;
        checks++;
        if (rd_r[0] !== D3) begin failures++; $display("FAIL wrrb_r0 got=%h exp=%h", rd_r[0], D3); end
        checks++;
        if (rd_rnb[0] !== D3) begin failures++; $display("FAIL wrrb_rnb0 got=%h exp=%h", rd_rnb[0], D3); end
        checks++;
        if (rd_r[1] !== 64'd0) begin failures++; $display("FAIL wrrb_r1 got=%h exp=0", rd_r[1]); end
    endtask

    task automatic test_zero_reg;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
        rd_addr = {5'd31, 5'd31};
        #1;
        checks++;
        if (rd_c !== '0) begin failures++; $display("FAIL xzr_bypass got=%h exp=0", rd_c); end
        tick;
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_c !== '0) begin failures++; $display("FAIL xzr_comb got=%h exp=0", rd_c); end
        checks++;
        if (rd_r !== '0) begin failures++; $display("FAIL xzr_reg got=%h exp=0", rd_r); end
        rd_addr = {5'd30, 5'd3};
        #1;
        checks++;
        if (rd_c[0] !== D3) begin failures++; $display("FAIL xzr_keep3 got=%h exp=%h", rd_c[0], D3); end
        checks++;
        if (rd_c[1] !== 64'd0) begin failures++; $display("FAIL xzr_keep30 got=%h exp=0", rd_c[1]); end
    endtask

    task automatic test_bypass;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h11;
        rd_addr = {5'd3, 5'd3};
        tick;
        wr_data = 64'h22;
        rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd_c[0] !== 64'h22) begin failures++; $display("FAIL byp_c0 got=%h exp=22", rd_c[0]); end
        checks++;
        if (rd_c[1] !== 64'h22) begin failures++; $display("FAIL byp_c1 got=%h exp=22", rd_c[1]); end
        checks++;
        if (rd_nb[0] !== 64'h11) begin failures++; $display("FAIL nobyp_c0 got=%h exp=11", rd_nb[0]); end
        tick;
        wr_en = 1'b0;
        checks++;
        if (rd_r[0] !== 64'h22) begin failures++; $display("FAIL byp_r0 got=%h exp=22", rd_r[0]); end
        checks++;
        if (rd_rnb[0] !== 64'h11) begin failures++; $display("FAIL nobyp_r0 got=%h exp=11", rd_rnb[0]); end
        #1;
        checks++;
        if (rd_nb[0] !== 64'h22) begin failures++; $display("FAIL nobyp_after_c got=%h exp=22", rd_nb[0]); end
        tick;
        checks++;
        if (rd_rnb[0] !== 64'h22) begin failures++; $display("FAIL nobyp_after_r got=%h exp=22", rd_rnb[0]); end
    endtask

    task automatic test_reset_mid_write;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h55;
        tick;
        reset = 1'b1; wr_data = 64'hFF;
        rd_addr = {5'd2, 5'd2};
        tick;
        reset = 1'b0; wr_en = 1'b0;
        #1;
        checks++;
        if (rd_c !== '0) begin failures++; $display("FAIL rstw_comb got=%h exp=0", rd_c); end
        checks++;
        if (rd_r !== '0) begin failures++; $display("FAIL rstw_reg_edge got=%h exp=0", rd_r); end
        tick;
        checks++;
        if (rd_r !== '0) begin failures++; $display("FAIL rstw_reg_next got=%h exp=0", rd_r); end
        checks++;
        if (rd_rnb !== '0) begin failures++; $display("FAIL rstw_rnb got=%h exp=0", rd_rnb); end
        rd_addr = {5'd7, 5'd3};
        #1;
        checks++;
        if (rd_c !== '0) begin failures++; $display("FAIL rstw_others got=%h exp=0", rd_c); end
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 8; i++) begin
            s_wr_en = 1'b1; s_wr_addr = 3'(i); s_wr_data = 3'(i);
            tick;
        end
        s_wr_en = 1'b0;
        for (int g = 0; g < 3; g++) begin
            for (int p = 0; p < 3; p++) s_rd_addr[p] = 3'((3 * g + p) % 8);
            #1;
            for (int p = 0; p < 3; p++) begin
                logic [2:0] a, exp_v;
                a = 3'((3 * g + p) % 8);
                exp_v = (a == 3'd7) ? 3'd0 : a;
                checks++;
                if (s_rd_data[p] !== exp_v) begin
                    failures++;
                    $display("FAIL sweep_idx%0d_port%0d got=%0d exp=%0d", a, p, s_rd_data[p], exp_v);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_write_readback;
        test_zero_reg;
        test_bypass;
        test_reset_mid_write;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
